// File: rtl/fifo_rd_arb_if.sv
// Bundle of the arbiter's FIFO read ports, channel controls and output stream.
// The master modport faces the arbiter; the slave modport faces FIFOs and consumer.
interface fifo_rd_arb_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 4,
    parameter int unsigned CW  = 2
);
    logic [NCH-1:0]    empty_i;
    logic [NCH*DW-1:0] dat_i;
    logic [NCH-1:0]    ren_o;
    logic [NCH-1:0]    en_i;
    logic              flush_i;
    logic [DW-1:0]     dat_o;
    logic [CW-1:0]     ch_o;
    logic              vld_o;
    logic              rdy_i;

    modport master (
        input  empty_i, dat_i, en_i, flush_i, rdy_i,
        output ren_o, dat_o, ch_o, vld_o
    );

    modport slave (
        output empty_i, dat_i, en_i, flush_i, rdy_i,
        input  ren_o, dat_o, ch_o, vld_o
    );
endinterface

// File: rtl/fifo_rd_arb.sv
// Round-robin read arbiter draining NCH FIFOs into one tagged valid/ready stream,
// with a 4-entry output queue and a credit scheme sized so rdy never reaches ren.
module fifo_rd_arb #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 4,
    parameter int unsigned CW  = 2
) (
    input logic         rclk,
    input logic         rst_i,
    fifo_rd_arb_if.master bus
);
    localparam int unsigned QD   = 4;
    localparam int unsigned QAW  = 2;
    localparam int unsigned CNTW = 3;

    logic [CW-1:0]   ptr;
    logic [CW-1:0]   chq;
    logic            infl;
    logic [CNTW-1:0] cnt;
    logic [QAW-1:0]  hd;
    logic [QAW-1:0]  tl;
    logic [DW-1:0]   qdat [QD];
    logic [CW-1:0]   qch  [QD];

    logic [NCH-1:0]   elig;
    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    logic             found;
    logic [CW:0]      sum;
    logic [CW-1:0]    win;
    logic [CW-1:0]    ptr_nxt;
    logic             issue;
    logic             pop;

    // Rotate eligibility so bit 0 is ptr, then take the first set bit.
    always_comb begin
        elig  = bus.en_i & ~bus.empty_i;
        dbl   = {elig, elig};
        rot   = NCH'(dbl >> ptr);
        found = 1'b0;
        sum   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (CW+1)'(i);
            end
        end
        if (sum >= (CW+1)'(NCH)) sum = sum - (CW+1)'(NCH);
        win = sum[CW-1:0];
        ptr_nxt = (32'(win) == NCH - 1) ? '0 : win + CW'(1);
    end

    // Credit: one slot per queued word plus the in-flight word.
    assign issue = !rst_i && !bus.flush_i && found &&
                   ((cnt + CNTW'(infl)) < CNTW'(QD));
    assign pop   = (cnt != '0) && bus.rdy_i;

    assign bus.ren_o = issue ? (NCH'(1) << win) : '0;
    assign bus.dat_o = qdat[hd];
    assign bus.ch_o  = qch[hd];
    assign bus.vld_o = (cnt != '0);

    always_ff @(posedge rclk or posedge rst_i) begin
        if (rst_i) begin
            ptr  <= '0;
            chq  <= '0;
            infl <= 1'b0;
            cnt  <= '0;
            hd   <= '0;
            tl   <= '0;
            for (int unsigned i = 0; i < QD; i++) begin
                qdat[i] <= '0;
                qch[i]  <= '0;
            end
        end else if (bus.flush_i) begin
            infl <= 1'b0;
            cnt  <= '0;
            hd   <= '0;
            tl   <= '0;
        end else begin
            infl <= issue;
            if (issue) begin
                chq <= win;
                ptr <= ptr_nxt;
            end
            // The FIFO data register for chq holds the word one cycle after ren.
            if (infl) begin
                qdat[tl] <= bus.dat_i[32'(chq)*DW +: DW];
                qch[tl]  <= chq;
                tl       <= tl + QAW'(1);
            end
            if (pop) hd <= hd + QAW'(1);
            case ({infl, pop})
                2'b10:   cnt <= cnt + CNTW'(1);
                2'b01:   cnt <= cnt - CNTW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_rd_arb.sv
// Bench for fifo_rd_arb: behavioural FIFOs plus a transaction-level reference model
// tracking issued-but-unconsumed words, checked every cycle on the falling edge.
module tb_fifo_rd_arb;
    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 4;
    localparam int unsigned CW  = 2;
    localparam int          FD  = 1024;

    logic rclk = 1'b0;
    logic rst_i;

    fifo_rd_arb_if #(.NCH(NCH), .DW(DW), .CW(CW)) bus ();

    fifo_rd_arb #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
        .rclk  (rclk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 rclk = ~rclk;

    // Behavioural FIFOs: ring storage, registered read data and empty flag.
    logic [DW-1:0]  fifo_mem [NCH][FD];
    int             frd [NCH];
    int             fwr [NCH];
    logic [DW-1:0]  fdat [NCH];
    logic [NCH-1:0] femp = '1;

    always @(posedge rclk) begin
        for (int k = 0; k < NCH; k++) begin
            if (bus.ren_o[k] && !femp[k]) begin
                fdat[k] <= fifo_mem[k][frd[k] % FD];
                frd[k] = frd[k] + 1;
            end
            femp[k] <= (fwr[k] == frd[k]);
        end
    end

    always_comb begin
        bus.dat_i   = '0;
        for (int k = 0; k < NCH; k++) bus.dat_i[k*DW +: DW] = fdat[k];
        bus.empty_i = femp;
    end

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference: ordered list of words granted and not yet consumed.
    typedef struct {
        logic [DW-1:0] d;
        int            c;
        int            t;
    } exp_t;

    exp_t eq[$];
    int   mptr = 0;

    always @(negedge rclk) begin
        bit            ev;
        bit            iss;
        int            w;
        logic [31:0]   exp_ren;
        exp_t          e;
        if (rst_i) begin
            chk("rst_ren", 32'(bus.ren_o), 32'd0);
            chk("rst_vld", 32'(bus.vld_o), 32'd0);
            chk("rst_dat", 32'(bus.dat_o), 32'd0);
            chk("rst_ch",  32'(bus.ch_o),  32'd0);
            eq.delete();
            mptr = 0;
        end else begin
            ev = (eq.size() > 0) && (eq[0].t + 2 <= cyc);
            chk("vld", 32'(bus.vld_o), 32'(ev));
            if (ev) begin
                chk("dat", 32'(bus.dat_o), 32'(eq[0].d));
                chk("ch",  32'(bus.ch_o),  32'(eq[0].c));
            end
            w = -1;
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (mptr + i) % NCH;
                if (w < 0 && bus.en_i[c] && !femp[c]) w = c;
            end
            iss     = !bus.flush_i && (w >= 0) && (eq.size() < 4);
            exp_ren = iss ? (32'd1 << w) : 32'd0;
            chk("ren", 32'(bus.ren_o), exp_ren);
            if (bus.flush_i) begin
                eq.delete();
            end else begin
                if (ev && bus.rdy_i) void'(eq.pop_front());
                if (iss) begin
                    e.d = fifo_mem[w][frd[w] % FD];
                    e.c = w;
                    e.t = cyc;
                    eq.push_back(e);
                    mptr = (w + 1) % NCH;
                end
            end
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic fill(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[k][fwr[k] % FD] = DW'($urandom);
            fwr[k]++;
        end
    endtask

    initial begin
        for (int k = 0; k < NCH; k++) begin
            frd[k]  = 0;
            fwr[k]  = 0;
            fdat[k] = '0;
        end
        rst_i       = 1'b1;
        bus.en_i    = '1;
        bus.flush_i = 1'b0;
        bus.rdy_i   = 1'b1;
        step(3);
        rst_i = 1'b0;
        step(2);

        // Fairness: every channel loaded, full throughput.
        for (int k = 0; k < NCH; k++) fill(k, 6);
        step(32);

        // Skip: only channels 1 and 3 hold data.
        fill(1, 3);
        fill(3, 3);
        step(14);

        // Back-pressure: queue fills to credit limit, then drains.
        bus.rdy_i = 1'b0;
        for (int k = 0; k < NCH; k++) fill(k, 6);
        step(12);
        bus.rdy_i = 1'b1;
        step(30);

        // Flush with words queued and one in flight.
        bus.rdy_i = 1'b0;
        for (int k = 0; k < NCH; k++) fill(k, 4);
        step(3);
        bus.flush_i = 1'b1;
        step(1);
        bus.flush_i = 1'b0;
        bus.rdy_i   = 1'b1;
        step(30);

        // Mask: channel 2 disabled.
        bus.en_i = 4'b1011;
        for (int k = 0; k < NCH; k++) fill(k, 5);
        step(30);
        bus.en_i = '1;
        step(10);

        // Reset mid-stream.
        for (int k = 0; k < NCH; k++) fill(k, 6);
        step(5);
        rst_i = 1'b1;
        step(2);
        rst_i = 1'b0;
        step(30);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bus.rdy_i   = ($urandom_range(0, 3) != 0);
            bus.flush_i = ($urandom_range(0, 39) == 0);
            rst_i       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) bus.en_i = NCH'($urandom);
            for (int k = 0; k < NCH; k++)
                if ((fwr[k] - frd[k]) < 8 && $urandom_range(0, 3) == 0) fill(k, $urandom_range(1, 3));
            step(1);
        end

        rst_i       = 1'b0;
        bus.flush_i = 1'b0;
        bus.rdy_i   = 1'b1;
        bus.en_i    = '1;
        step(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_rd_arb.md
# fifo_rd_arb

Read-side round-robin arbiter that drains up to NCH dual-clock FIFOs into a single valid/ready stream in the rclk domain. It issues read enables to the FIFOs, captures each returned word one cycle later, and tags the word with its source channel. A 4-entry output queue absorbs downstream back-pressure so that sustained throughput is one word per rclk cycle. It sits between the read ports of the per-channel FIFOs and the single consumer.

## Interface
- NCH, 4, number of FIFO channels (2..16)
- DW, 4, data width; must match the FIFO DW
- CW, 2, channel-tag width; must be at least clog2(NCH)
- rclk  in  1  read clock, shared with every FIFO read port
- rst_i  in  1  reset; asynchronous, active-high
- empty_i  in  NCH  per-channel FIFO empty flag; bit k belongs to channel k
- dat_i  in  NCH*DW  per-channel FIFO read data; channel k occupies [k*DW +: DW]
- ren_o  out  NCH  per-channel read enable; one-hot or zero
- en_i  in  NCH  channel enable mask; a disabled channel is never granted
- flush_i  in  1  synchronous flush of the output queue and any in-flight word
- dat_o  out  DW  head-of-queue data
- ch_o  out  CW  source channel of dat_o
- vld_o  out  1  dat_o and ch_o are valid
- rdy_i  in  1  consumer accepts the head word when vld_o & rdy_i

## Operation
- FIFO read contract: when a FIFO samples ren high with empty low, its dat_o updates on that rclk edge. The word is therefore valid on dat_i[k] in the cycle after ren_o[k].
- Grant eligibility: channel k is eligible when en_i[k]=1 and empty_i[k]=0.
- Issue condition: a grant is issued when flush_i=0, at least one channel is eligible, and credit is available.
  - credit = 4 - cnt - infl, where cnt is the queue occupancy (0..4, 3 bits) and infl is the in-flight flag.
  - Both cnt and infl are registered values. There is no combinational path from rdy_i to ren_o.
- Round-robin search:
  - The pointer ptr is CW bits wide and starts at 0.
  - The winner is the first eligible channel searched from ptr upward, wrapping modulo NCH.
  - On a grant, ptr <= winner+1, wrapping to 0 after NCH-1. Without a grant, ptr holds.
- On issue: ren_o[winner]=1 combinationally in the same cycle. At the next edge, infl<=1 and chq<=winner.
- Capture:
  - In any cycle with infl=1, dat_i[chq] and chq are written to the queue tail at that edge.
  - infl then clears, unless a new issue occurs in the same cycle.
- Queue: 4-entry circular buffer.
  - The head drives dat_o and ch_o; vld_o = (cnt != 0).
  - A pop occurs on vld_o & rdy_i.
  - Capture and pop in the same cycle leave cnt unchanged; the head advances and the tail advances.
  - Overflow cannot occur, because credit bounds cnt+infl to 4.
- Flush:
  - At the edge, cnt, the head/tail pointers and infl all go to 0.
  - A capture due in that cycle is discarded.
  - ren_o = 0 during the flush cycle. ptr is unchanged.
- Empty deassertion after a pop is delayed by the FIFO's pointer synchronizer. A channel may therefore appear empty for some cycles and simply be skipped. This is legal.

## Timing
- Reset values: ren_o=0, vld_o=0, dat_o=0, ch_o=0, cnt=0, infl=0, ptr=0, queue pointers 0. Reset applies at any time, including mid-transfer; in-flight data is lost.
- Latency from ren_o to vld_o (queue empty): 2 cycles.
  - Cycle N: ren_o.
  - Edge N+1: FIFO dat_o valid, infl=1.
  - Edge N+2: word is in the queue, vld_o=1.
- Throughput: one word per cycle sustained with rdy_i held high and at least one eligible channel.
- Stall behaviour: while vld_o & !rdy_i, dat_o and ch_o are held stable. Issue stops once cnt+infl=4.
- Disabling a channel (clearing en_i[k]) takes effect in the same cycle. A word already in flight is still captured.

## Test plan
- Fairness: reset; all 4 channels non-empty, en_i=4'hF, rdy_i=1 -> ren_o cycles 0001, 0010, 0100, 1000, 0001...; ch_o sequence 0,1,2,3,0 starting 2 cycles after the first ren; one word per cycle.
- Skip: only channels 1 and 3 non-empty, holding 3 words each (ch1: A1..A3, ch3: B1..B3) -> output A1,B1,A2,B2,A3,B3 with ch_o 1,3,1,3,1,3; then vld_o=0 and ren_o=0.
- Back-pressure: rdy_i=0 with all channels full -> exactly 4 ren_o pulses, then ren_o=0, cnt=4, vld_o=1 with dat_o stable; raise rdy_i -> 4 words in order, no loss, no duplicate.
- Flush: flush_i asserted one cycle after a ren_o, with cnt=2 -> next cycle vld_o=0; the in-flight word never appears at the output; the next grant goes to ptr's next eligible channel.
- Mask and reset: en_i=4'b1011 -> channel 2 is never granted. Asserting rst_i mid-stream -> all outputs go to 0 immediately. After release the first grant is channel 0.
